ip_bus_copy: RTL and testbench
==============================

# ip_bus_copy

Bus initiator that moves a block of bytes between two addresses on the internal 8-bit cartridge memory bus, using the same valid/ready/rdata_en protocol the RAM and other bus responders implement. It sits beside the CPU-side bus master and is started from a control register block (start pulse plus source, destination and length). With the fill option compiled in, it writes a constant byte instead of copying.

## Interface
- ADDR_W, 14: bus address width; address arithmetic wraps modulo 2^ADDR_W.
- LEN_W, 15: length counter width; maximum length 2^(LEN_W-1) bytes = 16384.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- src_addr  in  ADDR_W  source start address, sampled on accepted start.
- dst_addr  in  ADDR_W  destination start address, sampled on accepted start.
- length  in  LEN_W  byte count, sampled on accepted start; 0 = no-op.
- fill  in  1  fill mode select, sampled on start; present only with IP_BUS_COPY_FILL_EN.
- fill_data  in  8  fill byte, sampled on start; present only with IP_BUS_COPY_FILL_EN.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- bus_address  out  ADDR_W  request address.
- bus_valid  out  1  request valid.
- bus_ready  in  1  responder accepts request when high together with bus_valid.
- bus_write  out  1  1 = write, 0 = read.
- bus_wdata  out  8  write data.
- bus_rdata  in  8  read data; valid only while bus_rdata_en=1.
- bus_rdata_en  in  1  read data strobe; at least 1 cycle after read acceptance.

## Operation
- All outputs registered. Reset values: busy=0, done=0, bus_valid=0, bus_write=0, bus_address=0, bus_wdata=0; state IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: on start with length≠0, latch src, dst, count=length; go to RD_REQ (WR_REQ if fill mode). On start with length=0: go to DONE with no bus traffic.
- RD_REQ: bus_valid=1, bus_write=0, bus_address=src. Hold all bus outputs stable until bus_ready=1; then src←src+1 and go to RD_WAIT.
- RD_WAIT: bus_valid=0. On bus_rdata_en=1, capture bus_rdata into bus_wdata and go to WR_REQ. Ignore bus_rdata otherwise.
- WR_REQ: bus_valid=1, bus_write=1, bus_address=dst. Hold until bus_ready=1; then dst←dst+1 and count←count−1. If count was 1, go to DONE; otherwise go to RD_REQ (stay in WR_REQ if fill mode).
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- busy=1 in RD_REQ, RD_WAIT and WR_REQ only.
- Address wrap: src/dst increment from 2^ADDR_W−1 to 0, with no error.
- Overlapping regions are copied in ascending order; no overlap correction.
- Reset mid-transfer: immediate return to IDLE with reset values. done is not pulsed. Partially written data is left as is.
- A start pulse in the same cycle as the DONE pulse is ignored.

## Timing
- Start sampled on edge E. Bus request visible in cycle E+1 (busy=1 from E+1).
- Responder with bus_ready=1 and rdata_en one cycle after acceptance: 3 cycles per copied byte.
  - N-byte copy: done high in cycle E+1+3N.
  - length=0: done in cycle E+1.
- Fill mode with bus_ready=1: 1 cycle per byte; done in cycle E+1+N.
- Each bus_ready=0 cycle in RD_REQ/WR_REQ adds one cycle. Each extra rdata latency cycle adds one cycle.
- Only one read outstanding at any time. No new request is issued before rdata_en.

## Configuration
- IP_BUS_COPY_FILL_EN defined:
  - fill and fill_data ports exist.
  - When fill=1 at start, RD_REQ/RD_WAIT are skipped, every write uses the latched fill_data, and src_addr is unused.
- Not defined:
  - Ports absent; block is copy-only.
  - WR_REQ always returns to RD_REQ.

## Test plan
- Copy with RAM model (ready=1): preload 0x0100..0x0103 = 11,22,33,44; start src=0x0100, dst=0x2000, length=4 -> 0x2000..0x2003 = 11,22,33,44; done exactly 13 cycles after start; busy high for 12 cycles.
- Backpressure: random bus_ready=0 and 1–4 cycle rdata latency, 64-byte copy -> data correct; bus_address/bus_write/bus_wdata stable while valid&&!ready; never two reads outstanding.
- Wrap and zero length:
  - src=0x3FFE, dst=0x1000, length=4 -> reads 0x3FFE,0x3FFF,0x0000,0x0001.
  - length=0 -> done one cycle after start, bus_valid never set.
- Start ignored while busy; reset_n low mid-transfer -> bus_valid=0, busy=0 next cycle, no done pulse, next start works normally.
- Fill (IP_BUS_COPY_FILL_EN): fill=1, fill_data=0xA5, dst=0x0000, length=16384 -> whole RAM 0xA5; no reads issued; done at start+16385.

Source files
------------

// File: rtl/ip_bus_copy_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ip_bus_copy_if                                                |
// | Purpose  : 8-bit cartridge memory bus (valid/ready request, rdata_en     |
// |            read strobe) shared between a bus initiator and a responder.  |
// | Signals  : bus_address  request address (ADDR_W bits)                   |
// |            bus_valid    request valid                                    |
// |            bus_ready    responder accepts when high with bus_valid       |
// |            bus_write    1 = write, 0 = read                              |
// |            bus_wdata    write data                                       |
// |            bus_rdata    read data, valid while bus_rdata_en = 1          |
// |            bus_rdata_en read data strobe                                 |
// | Modports : master (initiator side), slave (responder side)              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ip_bus_copy_if #(
  parameter int ADDR_W = 14
) ();
  logic [ADDR_W-1:0] bus_address;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_write;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;
  logic              bus_rdata_en;

  modport master (
    output bus_address, bus_valid, bus_write, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en
  );

  modport slave (
    input  bus_address, bus_valid, bus_write, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en
  );
endinterface
`default_nettype wire

// File: rtl/ip_bus_copy.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ip_bus_copy                                                   |
// | Purpose  : Bus initiator that copies a block of bytes from src_addr to   |
// |            dst_addr over the 8-bit cartridge memory bus, one read then   |
// |            one write per byte, ascending addresses, wrapping mod 2^ADDR_W|
// |            With IP_BUS_COPY_FILL_EN defined, fill=1 at start writes the  |
// |            latched fill_data to every destination byte with no reads.    |
// | Ports    : clk, reset_n (sync, active low)                               |
// |            start/src_addr/dst_addr/length command (length 0 = no-op)     |
// |            fill/fill_data (only with IP_BUS_COPY_FILL_EN)                |
// |            busy (transfer in progress), done (1-cycle completion pulse)  |
// |            bus (ip_bus_copy_if.master)                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ip_bus_copy #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
) (
  input  wire                clk,
  input  wire                reset_n,
  input  wire                start,
  input  wire   [ADDR_W-1:0] src_addr,
  input  wire   [ADDR_W-1:0] dst_addr,
  input  wire   [LEN_W-1:0]  length,
`ifdef IP_BUS_COPY_FILL_EN
  input  wire                fill,
  input  wire   [7:0]        fill_data,
`endif
  output logic               busy,
  output logic               done,
  ip_bus_copy_if.master      bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        r_state,   w_state_nxt;
  logic [ADDR_W-1:0] r_src,     w_src_nxt;
  logic [ADDR_W-1:0] r_dst,     w_dst_nxt;
  logic [LEN_W-1:0]  r_count,   w_count_nxt;
  logic [7:0]        r_wdata,   w_wdata_nxt;
  logic              r_fill,    w_fill_nxt;
  logic              r_busy,    w_busy_nxt;
  logic              r_done,    w_done_nxt;
  logic              r_valid,   w_valid_nxt;
  logic              r_write,   w_write_nxt;
  logic [ADDR_W-1:0] r_address, w_address_nxt;

  logic              w_start_fill;
  logic [7:0]        w_start_fill_data;

`ifdef IP_BUS_COPY_FILL_EN
  assign w_start_fill      = fill;
  assign w_start_fill_data = fill_data;
`else
  assign w_start_fill      = 1'b0;
  assign w_start_fill_data = 8'h00;
`endif

  // State and registered outputs. Outputs are loaded from the decode of the
  // next state so every bus/status output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_count   <= '0;
      r_wdata   <= '0;
      r_fill    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_write   <= 1'b0;
      r_address <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_dst     <= w_dst_nxt;
      r_count   <= w_count_nxt;
      r_wdata   <= w_wdata_nxt;
      r_fill    <= w_fill_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_valid   <= w_valid_nxt;
      r_write   <= w_write_nxt;
      r_address <= w_address_nxt;
    end
  end

  // Next-state and datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_count_nxt = r_count;
    w_wdata_nxt = r_wdata;
    w_fill_nxt  = r_fill;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_nxt   = src_addr;
          w_dst_nxt   = dst_addr;
          w_count_nxt = length;
          w_fill_nxt  = w_start_fill;
          if (length == '0) begin
            w_state_nxt = S_DONE;
          end else if (w_start_fill) begin
            w_state_nxt = S_WR_REQ;
            w_wdata_nxt = w_start_fill_data;
          end else begin
            w_state_nxt = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (bus.bus_ready) begin
          w_src_nxt   = r_src + ADDR_W'(1);
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus.bus_rdata_en) begin
          w_wdata_nxt = bus.bus_rdata;
          w_state_nxt = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (bus.bus_ready) begin
          w_dst_nxt   = r_dst + ADDR_W'(1);
          w_count_nxt = r_count - LEN_W'(1);
          if (r_count == LEN_W'(1)) begin
            w_state_nxt = S_DONE;
          end else if (r_fill) begin
            w_state_nxt = S_WR_REQ;
          end else begin
            w_state_nxt = S_RD_REQ;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the next state. The request address follows the pointer
  // of the upcoming request and otherwise holds, so it stays stable under
  // backpressure.
  always_comb begin
    w_busy_nxt    = (w_state_nxt == S_RD_REQ) || (w_state_nxt == S_RD_WAIT) ||
                    (w_state_nxt == S_WR_REQ);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_valid_nxt   = (w_state_nxt == S_RD_REQ) || (w_state_nxt == S_WR_REQ);
    w_write_nxt   = (w_state_nxt == S_WR_REQ);
    w_address_nxt = r_address;
    if (w_state_nxt == S_RD_REQ) begin
      w_address_nxt = w_src_nxt;
    end else if (w_state_nxt == S_WR_REQ) begin
      w_address_nxt = w_dst_nxt;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign bus.bus_valid   = r_valid;
  assign bus.bus_write   = r_write;
  assign bus.bus_address = r_address;
  assign bus.bus_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ip_bus_copy.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ip_bus_copy                                                |
// | Purpose  : Self-checking bench for ip_bus_copy. A RAM responder with     |
// |            configurable ready probability and read latency, a reference  |
// |            model of the expected bus transactions and memory image, and  |
// |            directed commands with literal expectations.                  |
// |            Fill test compiled only with IP_BUS_COPY_FILL_EN.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ip_bus_copy;
  localparam int ADDR_W = 14;
  localparam int LEN_W  = 15;
  localparam int MEM    = 1 << ADDR_W;

  typedef struct {
    bit wr;
    int addr;
    int data;
  } txn_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  length = '0;
`ifdef IP_BUS_COPY_FILL_EN
  logic              fill = 1'b0;
  logic [7:0]        fill_data = 8'h00;
`endif
  logic              busy;
  logic              done;

  ip_bus_copy_if #(.ADDR_W(ADDR_W)) bus_if ();

  ip_bus_copy #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
`ifdef IP_BUS_COPY_FILL_EN
    .fill     (fill),
    .fill_data(fill_data),
`endif
    .busy     (busy),
    .done     (done),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram [MEM];
  logic [7:0] model_mem [MEM];
  txn_t       exp_q[$];
  int         rd_log[$];

  int ready_pct = 100;
  int lat_min   = 1;
  int lat_max   = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Responder + per-cycle compare against the transaction model.
  bit                rd_pend = 1'b0;
  int                rd_cnt = 0;
  logic [7:0]        rd_data = 8'h00;
  int                outstanding = 0;
  bit                prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              prev_write = 1'b0;
  logic [7:0]        prev_wdata = 8'h00;

  always @(negedge clk) begin : p_cmp
    txn_t e;
    bus_if.bus_rdata_en = 1'b0;
    bus_if.bus_rdata    = 8'($urandom);
    if (!reset_n) begin
      rd_pend          = 1'b0;
      outstanding      = 0;
      prev_stall       = 1'b0;
      bus_if.bus_ready = 1'b0;
    end else begin
      chk("busy_and_done", 32'(busy & done), 32'd0);
      chk("valid_without_busy", 32'(bus_if.bus_valid & ~busy), 32'd0);
      if (bus_if.bus_valid) chk("request_while_read_outstanding", outstanding, 0);
      if (prev_stall) begin
        chk("stall_valid", 32'(bus_if.bus_valid), 32'd1);
        chk("stall_address", 32'(bus_if.bus_address), 32'(prev_addr));
        chk("stall_write", 32'(bus_if.bus_write), 32'(prev_write));
        chk("stall_wdata", 32'(bus_if.bus_wdata), 32'(prev_wdata));
      end
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus_if.bus_rdata_en = 1'b1;
          bus_if.bus_rdata    = rd_data;
          rd_pend             = 1'b0;
          outstanding--;
        end
      end
      bus_if.bus_ready = ($urandom_range(99) < 32'(ready_pct));
      if (bus_if.bus_valid && bus_if.bus_ready) begin
        chk("txn_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("txn_write", 32'(bus_if.bus_write), 32'(e.wr));
          chk("txn_address", 32'(bus_if.bus_address), e.addr);
          if (bus_if.bus_write) begin
            if (e.wr) chk("txn_wdata", 32'(bus_if.bus_wdata), e.data);
          end
        end
        if (bus_if.bus_write) begin
          ram[bus_if.bus_address] = bus_if.bus_wdata;
        end else begin
          rd_log.push_back(int'(bus_if.bus_address));
          rd_pend = 1'b1;
          rd_cnt  = int'($urandom_range(lat_max, lat_min));
          rd_data = ram[bus_if.bus_address];
          outstanding++;
        end
      end
      prev_stall = bus_if.bus_valid && !bus_if.bus_ready;
      prev_addr  = bus_if.bus_address;
      prev_write = bus_if.bus_write;
      prev_wdata = bus_if.bus_wdata;
    end
  end

  // Expected transaction list and final memory image for one command.
  task automatic expect_cmd(input int s, input int d, input int len, input bit f,
                            input logic [7:0] fd);
    for (int i = 0; i < len; i++) begin
      int a;
      int b;
      logic [7:0] v;
      txn_t t;
      a = (s + i) % MEM;
      b = (d + i) % MEM;
      if (f) begin
        v = fd;
      end else begin
        v = model_mem[a];
        t.wr = 1'b0; t.addr = a; t.data = 0;
        exp_q.push_back(t);
      end
      t.wr = 1'b1; t.addr = b; t.data = int'(v);
      exp_q.push_back(t);
      model_mem[b] = v;
    end
  endtask

  task automatic drive_cmd(input int s, input int d, input int len, input bit f,
                           input logic [7:0] fd);
    src_addr = ADDR_W'(s);
    dst_addr = ADDR_W'(d);
    length   = LEN_W'(len);
`ifdef IP_BUS_COPY_FILL_EN
    fill      = f;
    fill_data = fd;
`else
    if (f || fd != 8'h00) $display("note: fill request ignored in copy-only build");
`endif
  endtask

  // Issue a command, optionally pulse start again in cycles g1/g2 (which must
  // be ignored), and check completion timing, idle afterwards and memory.
  task automatic run_cmd(input int s, input int d, input int len, input bit f,
                         input logic [7:0] fd, input int exp_done, input int g1,
                         input int g2, input int bound);
    int n;
    int busy_cnt;
    int done_at;
    int mism;
    rd_log.delete();
    expect_cmd(s, d, len, f, fd);
    @(posedge clk); #1;
    drive_cmd(s, d, len, f, fd);
    start = 1'b1;
    @(posedge clk); #1;
    n = 1; busy_cnt = 0; done_at = 0;
    forever begin
      start = (n == g1) || (n == g2);
      if (start) drive_cmd(16'h3000, 16'h3100, 5, 1'b0, 8'h00);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_at = n; break; end
      if (n >= bound) break;
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_within_bound", 32'(done_at > 0), 32'd1);
    if (exp_done > 0) chk("done_cycle", done_at, exp_done);
    chk("busy_span", busy_cnt, done_at - 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("idle_after_done", 32'(busy | bus_if.bus_valid), 32'd0);
      @(negedge clk);
    end
    chk("all_txns_seen", exp_q.size(), 0);
    mism = 0;
    for (int i = 0; i < MEM; i++) if (ram[i] !== model_mem[i]) mism++;
    chk("memory_image", mism, 0);
  endtask

  initial begin : p_main
    int nonfill;
    for (int i = 0; i < MEM; i++) ram[i] = 8'($urandom);
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22;
    ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
    ram[16'h0200] = 8'hAA; ram[16'h0201] = 8'hBB; ram[16'h0202] = 8'hCC;
    model_mem = ram;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("reset_write", 32'(bus_if.bus_write), 32'd0);
    chk("reset_address", 32'(bus_if.bus_address), 32'd0);
    chk("reset_wdata", 32'(bus_if.bus_wdata), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 4-byte copy, ready=1, 1-cycle latency; stray starts while busy and in DONE.
    run_cmd(16'h0100, 16'h2000, 4, 1'b0, 8'h00, 13, 5, 13, 200);
    chk("copy_byte0", 32'(ram[16'h2000]), 32'h11);
    chk("copy_byte1", 32'(ram[16'h2001]), 32'h22);
    chk("copy_byte2", 32'(ram[16'h2002]), 32'h33);
    chk("copy_byte3", 32'(ram[16'h2003]), 32'h44);
    chk("copy_reads", rd_log.size(), 4);

    // Overlapping ascending copy smears the first byte forward.
    run_cmd(16'h0100, 16'h0101, 3, 1'b0, 8'h00, 10, 0, 0, 200);
    chk("overlap_0101", 32'(ram[16'h0101]), 32'h11);
    chk("overlap_0102", 32'(ram[16'h0102]), 32'h11);
    chk("overlap_0103", 32'(ram[16'h0103]), 32'h11);

    // Source address wrap.
    run_cmd(16'h3FFE, 16'h1000, 4, 1'b0, 8'h00, 13, 0, 0, 200);
    chk("wrap_reads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("wrap_rd0", rd_log[0], 32'h3FFE);
      chk("wrap_rd1", rd_log[1], 32'h3FFF);
      chk("wrap_rd2", rd_log[2], 32'h0000);
      chk("wrap_rd3", rd_log[3], 32'h0001);
    end

    // Destination address wrap.
    run_cmd(16'h0200, 16'h3FFE, 3, 1'b0, 8'h00, 10, 0, 0, 200);
    chk("dwrap_3ffe", 32'(ram[16'h3FFE]), 32'hAA);
    chk("dwrap_3fff", 32'(ram[16'h3FFF]), 32'hBB);
    chk("dwrap_0000", 32'(ram[16'h0000]), 32'hCC);

    // Zero length: done in the first cycle, no traffic; stray start in DONE.
    run_cmd(16'h0500, 16'h0600, 0, 1'b0, 8'h00, 1, 1, 0, 50);
    chk("zero_len_reads", rd_log.size(), 0);

    // Backpressure and variable read latency.
    ready_pct = 60; lat_min = 1; lat_max = 4;
    run_cmd(16'h0400, 16'h0800, 64, 1'b0, 8'h00, -1, 0, 0, 5000);
    chk("bp_reads", rd_log.size(), 64);
    ready_pct = 100; lat_min = 1; lat_max = 1;

    // Reset in the middle of a transfer.
    rd_log.delete();
    expect_cmd(16'h0C00, 16'h0D00, 32, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive_cmd(16'h0C00, 16'h0D00, 32, 1'b0, 8'h00);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_valid", 32'(bus_if.bus_valid), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midreset_no_done", 32'(done | busy), 32'd0);
    end
    model_mem = ram;
    run_cmd(16'h0100, 16'h2100, 2, 1'b0, 8'h00, 7, 0, 0, 200);
    chk("after_reset_byte0", 32'(ram[16'h2100]), 32'h11);

`ifdef IP_BUS_COPY_FILL_EN
    // Fill the whole RAM with one byte, one cycle per write.
    run_cmd(16'h0000, 16'h0000, 16384, 1'b1, 8'hA5, 16385, 0, 0, 17000);
    chk("fill_reads", rd_log.size(), 0);
    nonfill = 0;
    for (int i = 0; i < MEM; i++) if (ram[i] !== 8'hA5) nonfill++;
    chk("fill_image", nonfill, 0);
`else
    nonfill = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
